// File: rtl/alu_pipe.sv
// Parametrised add/sub ALU with carry/overflow/zero/negative flags, followed by
// a STAGES-deep valid/ready pipeline driven by a global enable, plus sticky overflow.
module alu_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             co;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  logic [WIDTH-1:0] bx;
  logic             cin;
  logic             pass_op;
  logic [WIDTH:0]   sum;
  res_t             res_c;

  res_t             stg [STAGES];
  logic [STAGES-1:0] vld;
  logic             en;

  // Opcode decode into the single adder's B operand and carry-in
  always_comb begin
    bx      = '0;
    cin     = 1'b0;
    pass_op = 1'b0;
    case (opcode)
      3'd0: begin bx = b;            cin = 1'b0; end
      3'd1: begin bx = b;            cin = 1'b1; end
      3'd2: begin bx = ~b;           cin = 1'b0; end
      3'd3: begin bx = ~b;           cin = 1'b1; end
      3'd4: begin bx = '0;           cin = 1'b0; pass_op = 1'b1; end
      3'd5: begin bx = '0;           cin = 1'b1; end
      3'd6: begin bx = {WIDTH{1'b1}}; cin = 1'b0; end
      default: begin bx = '0;        cin = 1'b0; pass_op = 1'b1; end
    endcase
  end

  always_comb begin
    sum        = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    res_c      = '0;
    res_c.y    = sum[WIDTH-1:0];
    res_c.co   = sum[WIDTH] & ~pass_op;
    res_c.ovf  = ~pass_op & (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    res_c.zero = (sum[WIDTH-1:0] == '0);
    res_c.neg  = sum[WIDTH-1];
  end

  assign out_valid = vld[LAST];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;

  // Data only loads behind a valid beat so outputs never move while out_valid=0
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      if (in_valid) stg[0] <= res_c;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) stg[i] <= stg[i-1];
      end
    end
  end

  // Set on an overflowing transfer takes priority over clear
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && stg[LAST].ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign y    = stg[LAST].y;
  assign co   = stg[LAST].co;
  assign ovf  = stg[LAST].ovf;
  assign zero = stg[LAST].zero;
  assign neg  = stg[LAST].neg;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's fixed-width ALU. It performs the same 3-bit opcode set (add, add+1, sub−1, sub, pass, increment, decrement, pass) on WIDTH-bit operands. The result passes through a configurable pipeline of STAGES register stages with valid/ready flow control. It reports carry, signed overflow, zero and negative flags, plus a sticky overflow status. It sits between an operand source and a result consumer, either of which may stall.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- STAGES, 2, number of register stages between operand acceptance and result presentation (1..4)
- clk  input  1  clock, all state updates on rising edge
- arst  input  1  asynchronous reset, active-high; clears all state immediately
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A (two's complement)
- b  input  WIDTH  operand B (two's complement)
- opcode  input  3  operation select
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- y  output  WIDTH  result
- co  output  1  carry out of adder (bit WIDTH)
- ovf  output  1  signed overflow of this result
- zero  output  1  y == 0
- neg  output  1  y[WIDTH-1]
- ovf_sticky  output  1  set once any transferred result had ovf=1
- clr_sticky  input  1  synchronous clear of ovf_sticky

## Operation
- Single adder form: sum[WIDTH:0] = {0,a} + {0,bx} + cin. co = sum[WIDTH], y = sum[WIDTH-1:0].
- The opcode sets bx and cin as follows:
  - 0: b, 0 → a+b
  - 1: b, 1 → a+b+1
  - 2: ~b, 0 → a−b−1
  - 3: ~b, 1 → a−b
  - 4: 0, 0 → a (co forced 0)
  - 5: 0, 1 → a+1
  - 6: all-ones, 0 → a−1
  - 7: 0, 0 → a (co forced 0)
- For subtraction (2, 3, 6), co=1 means no borrow.
- ovf = (a[W-1] == bx[W-1]) && (y[W-1] != a[W-1]). ovf is forced 0 for opcodes 4 and 7.
- Arithmetic and flags are combinational from the inputs. The packed {y, co, ovf, zero, neg} enters stage 1 on acceptance.
- Stage k+1 loads from stage k. The last stage drives the outputs directly; there is no output logic after the final register.
- Each stage has a valid bit. Data bits of an invalid stage are don't-care but must not glitch outputs while out_valid=0; the implementation holds the previous value.
- Flow control is a global pipeline enable: en = !out_valid || out_ready; in_ready = en.
- When en=1, all stages shift by one, and stage 1 valid = in_valid.
- When en=0, all stages hold. Bubbles are not compressed.
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- ovf_sticky is updated each cycle:
  - it is set on a transfer with ovf=1;
  - it is cleared by clr_sticky;
  - if a set and a clear occur in the same cycle, set wins (result 1).
- Reset (arst=1): every stage valid=0, every data/flag bit=0, ovf_sticky=0.
  - Outputs during and immediately after reset: out_valid=0, y=0, co=ovf=zero=neg=0, in_ready=1.
  - In-flight beats are discarded.
  - Deassertion is synchronised by the system; the block needs no internal synchroniser.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. visible in the cycle following edge N+STAGES−1. Latency is STAGES cycles, provided out_ready stayed high.
- Throughput: one beat per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational from out_ready). y and flags are held stable until the transfer.
- in_ready depends combinationally on out_ready; there is no path from in_valid to in_ready.
- With STAGES=1, the block is a single register slice with the same rules.
- A reset mid-stall drops out_valid asynchronously, without waiting for a clock.

## Test plan
- WIDTH=16, STAGES=2, out_ready=1: a=0x7FFF, b=0x0001, op=0 → two cycles later y=0x8000, co=0, ovf=1, neg=1, zero=0.
- op=3, a=b=0x0005 → y=0x0000, co=1, zero=1, ovf=0. op=6, a=0x0000 → y=0xFFFF, co=0, neg=1, ovf=0.
- Sweep all 8 opcodes with a=0x1234, b=0x00FF → y = 0x1333, 0x1334, 0x1134, 0x1135, 0x1234, 0x1235, 0x1233, 0x1234. co is 0 for opcodes 0, 1, 4 and 7, and 1 for opcodes 2, 3, 5? No — check opcode 5: 0x1234 + 0 + 1 gives co=0. Required co values: 0, 0, 1, 1, 0, 0, 1, 0.
- Backpressure: send 4 back-to-back beats and hold out_ready=0 for 3 cycles once out_valid rises. Required: in_ready=0 during the stall, y held stable, all 4 results emerge in order with none lost or duplicated.
- Reset: assert arst between clock edges while 2 beats are in flight → out_valid, y and flags go to 0 before the next edge. After release, in_ready=1 and the next beat has normal latency.
- Sticky: transfer an overflowing beat → ovf_sticky=1. Then transfer an overflowing beat in the same cycle clr_sticky=1 → ovf_sticky stays 1. A clr_sticky with no overflowing transfer → ovf_sticky=0 next cycle.
